// File: rtl/problem_c.sv
// problem_c: fuel/battery gauge glyph decoder with a blinking low-level warning.
//   Ports: iClk_in (clock), iRstN_in (async active-low reset), iFLvl_in[3:0] (level),
//   iBMode_in (1 = battery, 0 = fuel), oFGauge_out[6:0] (registered segments A..G, active-high).
module problem_c #(
  parameter int BLINK_DIV = 16
) (
  input  logic       iClk_in,
  input  logic       iRstN_in,
  input  logic [3:0] iFLvl_in,
  input  logic       iBMode_in,
  output logic [6:0] oFGauge_out
);
  localparam int CW = $clog2(BLINK_DIV);
  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_wrap;
  logic          w_warn;
  logic [6:0]    w_glyph;
  assign w_wrap = r_cnt == CW'(BLINK_DIV - 1);
  always_comb begin
    w_warn  = iBMode_in ? (iFLvl_in < 4'd4) : (iFLvl_in == 4'd0);
    w_glyph = iBMode_in ?
              (iFLvl_in < 4'd4  ? 7'b0001110 :
               iFLvl_in < 4'd12 ? 7'b0011111 : 7'b0110111) :
              (iFLvl_in == 4'd0 ? 7'b1001111 :
               iFLvl_in < 4'd5  ? 7'b0001000 :
               iFLvl_in < 4'd9  ? 7'b0001001 :
               iFLvl_in < 4'd13 ? 7'b1001001 : 7'b1000111);
  end
  // The output uses the phase held before this edge's toggle, so a warning
  // stays lit for a full BLINK_DIV cycles after reset release.
  always_ff @(posedge iClk_in or negedge iRstN_in) begin
    if (!iRstN_in) begin
      r_cnt       <= '0;
      r_phase     <= 1'b0;
      oFGauge_out <= '0;
    end else begin
      r_cnt       <= w_wrap ? '0 : r_cnt + 1'b1;
      r_phase     <= r_phase ^ w_wrap;
      oFGauge_out <= (w_warn && r_phase) ? 7'b0000000 : w_glyph;
    end
  end
endmodule

// File: tb/tb_problem_c.sv
// tb_problem_c: vector table, directed blink sequences and random stimulus against a reference model.
module tb_problem_c;
  localparam int BD = 16;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] lvl;
  logic       mode;
  logic [6:0] gauge;
  int n_pass = 0;
  int n_tot  = 0;
  int k      = 0;
  problem_c #(.BLINK_DIV(BD)) dut (
    .iClk_in(clk),
    .iRstN_in(rst_n),
    .iFLvl_in(lvl),
    .iBMode_in(mode),
    .oFGauge_out(gauge)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       m;
    logic [3:0] l;
    logic [6:0] e;
  } vec_t;
  vec_t vt [15];
  function automatic logic [6:0] model(logic m, logic [3:0] l, int edge_no);
    logic [6:0] g;
    bit warn;
    bit dark;
    int v;
    v = l;
    dark = (((edge_no - 1) / BD) % 2) == 1;
    if (m) begin
      warn = v <= 3;
      g = v <= 3 ? 7'b0001110 : v <= 11 ? 7'b0011111 : 7'b0110111;
    end else begin
      warn = v == 0;
      if (v == 0) g = 7'b1001111;
      else if (v <= 4) g = 7'b0001000;
      else if (v <= 8) g = 7'b0001001;
      else if (v <= 12) g = 7'b1001001;
      else g = 7'b1000111;
    end
    return (warn && dark) ? 7'b0 : g;
  endfunction
  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, k);
  endtask
  task automatic step(string name);
    logic [6:0] e;
    @(posedge clk);
    k++;
    e = model(mode, lvl, k);
    #1;
    check(name, gauge, e);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_async", gauge, 7'b0);
    @(posedge clk);
    #1 check("reset_hold", gauge, 7'b0);
    #2 rst_n = 1'b1;
    k = 0;
  endtask
  initial begin
    vt[0]  = '{1'b0, 4'h1, 7'b0001000};
    vt[1]  = '{1'b0, 4'h4, 7'b0001000};
    vt[2]  = '{1'b0, 4'h5, 7'b0001001};
    vt[3]  = '{1'b0, 4'h8, 7'b0001001};
    vt[4]  = '{1'b0, 4'h9, 7'b1001001};
    vt[5]  = '{1'b0, 4'hC, 7'b1001001};
    vt[6]  = '{1'b0, 4'hD, 7'b1000111};
    vt[7]  = '{1'b0, 4'hF, 7'b1000111};
    vt[8]  = '{1'b0, 4'h0, 7'b1001111};
    vt[9]  = '{1'b1, 4'h3, 7'b0001110};
    vt[10] = '{1'b1, 4'h4, 7'b0011111};
    vt[11] = '{1'b1, 4'h7, 7'b0011111};
    vt[12] = '{1'b1, 4'hB, 7'b0011111};
    vt[13] = '{1'b1, 4'hC, 7'b0110111};
    vt[14] = '{1'b1, 4'hF, 7'b0110111};
    rst_n = 1'b0;
    mode  = 1'b0;
    lvl   = 4'h5;
    #3 check("reset_t0", gauge, 7'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    k = 1;
    #1 check("first_edge", gauge, 7'b0001001);
    // table vectors, all within the first lit half-period
    for (int i = 0; i < 15; i++) begin
      mode = vt[i].m;
      lvl  = vt[i].l;
      @(posedge clk);
      k++;
      #1 check($sformatf("vec%0d", i), gauge, vt[i].e);
    end
    // fuel sweep 1..F, two cycles each, then wrap into blinking E
    do_reset();
    mode = 1'b0;
    for (int v = 1; v <= 16; v++) begin
      lvl = 4'(v);
      step("sweep");
      step("sweep");
    end
    for (int i = 0; i < 40; i++) step("sweep_e");
    // blink cadence: three full periods from reset
    do_reset();
    mode = 1'b0;
    lvl  = 4'h0;
    for (int i = 0; i < 3 * 2 * BD; i++) begin
      step("cadence");
      check("cadence_abs", gauge, ((i / BD) % 2 == 0) ? 7'b1001111 : 7'b0);
    end
    // mode toggle while dark, phase continues afterwards
    do_reset();
    mode = 1'b1;
    lvl  = 4'h2;
    for (int i = 0; i < BD + 3; i++) step("toggle_pre");
    check("toggle_dark", gauge, 7'b0);
    mode = 1'b0;
    lvl  = 4'hA;
    step("toggle_new");
    check("toggle_abs", gauge, 7'b1001001);
    mode = 1'b1;
    lvl  = 4'h2;
    for (int i = 0; i < 2 * BD; i++) step("toggle_post");
    // async reset mid-blink: restart lit for a full half-period
    mode = 1'b0;
    lvl  = 4'h0;
    do_reset();
    for (int i = 0; i < BD; i++) begin
      step("rst_relit");
      check("rst_lit_abs", gauge, 7'b1001111);
    end
    step("rst_dark");
    check("rst_dark_abs", gauge, 7'b0);
    // random stimulus
    for (int i = 0; i < 400; i++) begin
      mode = 1'($urandom);
      lvl  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      step("random");
      if ($urandom_range(0, 7) == 0) step("random_hold");
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
